aud_player_stereo: RTL and testbench

Parametrised stereo serializer for the audio DAC path, succeeding the mono 16-bit player. It accepts left/right sample pairs through a one-entry valid/ready buffer and serialises them MSB-first on `o_aud_dacdat`, synchronised to the codec's `i_daclrck`. Sample width and framing mode are configurable: I2S (one-BCLK delay) or left-justified. Underruns are flagged. It sits between the DSP sample source and the codec's DACDAT pin, entirely in the `i_bclk` domain.

---
 rtl/aud_player_stereo.sv | 162 ++++++++++++++++
 tb/tb_aud_player_stereo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aud_player_stereo.sv
// aud_player_stereo
//   Stereo I2S / left-justified serializer for the audio DAC path. A one-entry
//   {left, right} buffer is filled through a valid/ready handshake. It is
//   drained into the shift registers at each frame start, which is the falling
//   edge of LRCK. Each channel's bits are then driven MSB-first on the DACDAT
//   pin. Everything runs on the posedge of the bit clock.
//
// Ports
//   i_bclk        bit clock (only clock)
//   i_rst_n       asynchronous active-low reset
//   i_daclrck     codec LR clock, low = left, high = right (bclk-synchronous)
//   i_en          playback enable
//   i_left_data   left sample  (DATA_W, two's complement)
//   i_right_data  right sample (DATA_W, two's complement)
//   i_valid       sample pair valid
//   o_ready       buffer empty / pair can be accepted
//   o_aud_dacdat  registered serial data
//   o_underrun    one-cycle pulse: frame started with an empty buffer
module aud_player_stereo #(
  parameter int DATA_W   = 16,
  parameter bit I2S_MODE = 1'b1
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_left_data,
  input  logic [DATA_W-1:0] i_right_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  state_t              state, state_next;
  logic                lrck_q;
  logic                buf_full, buf_full_next;
  logic [DATA_W-1:0]   buf_l, buf_r;
  logic [DATA_W-1:0]   sh_l, sh_l_next;
  logic [DATA_W-1:0]   sh_r, sh_r_next;
  logic                chan, chan_next;      // 0 = left, 1 = right
  logic [CNT_W-1:0]    cnt, cnt_next;        // bits already driven this channel
  logic                dac_next;
  logic                und_next;

  logic lrck_fall, lrck_rise, accept;

  assign lrck_fall = lrck_q & ~i_daclrck;
  assign lrck_rise = ~lrck_q & i_daclrck;
  assign accept    = i_valid & ~buf_full;
  assign o_ready   = ~buf_full;

  // The shift registers shift left as bits go out, so the active channel's
  // next bit is always its MSB. cnt counts the bits already emitted; in
  // left-justified mode the MSB leaves on the edge cycle itself, so cnt starts
  // at 1 there.
  always_comb begin
    state_next    = state;
    buf_full_next = buf_full;
    sh_l_next     = sh_l;
    sh_r_next     = sh_r;
    chan_next     = chan;
    cnt_next      = cnt;
    dac_next      = 1'b0;
    und_next      = 1'b0;

    if (accept) begin
      buf_full_next = 1'b1;
    end

    if (!i_en) begin
      state_next = IDLE;
    end else if (lrck_fall) begin
      // Frame start. accept and buf_full are mutually exclusive, so a pair
      // arriving on this same edge stays in the buffer for the next frame.
      if (buf_full) begin
        sh_l_next     = buf_l;
        sh_r_next     = buf_r;
        buf_full_next = 1'b0;
      end else begin
        sh_l_next = '0;
        sh_r_next = '0;
        und_next  = 1'b1;
      end
      chan_next = 1'b0;
      if (I2S_MODE) begin
        state_next = DELAY;
        cnt_next   = '0;
      end else begin
        state_next = SHIFT;
        dac_next   = sh_l_next[DATA_W-1];
        sh_l_next  = {sh_l_next[DATA_W-2:0], 1'b0};
        cnt_next   = CNT_W'(1);
      end
    end else if (lrck_rise && (state != IDLE)) begin
      chan_next = 1'b1;
      if (I2S_MODE) begin
        state_next = DELAY;
        cnt_next   = '0;
      end else begin
        state_next = SHIFT;
        dac_next   = sh_r[DATA_W-1];
        sh_r_next  = {sh_r[DATA_W-2:0], 1'b0};
        cnt_next   = CNT_W'(1);
      end
    end else begin
      case (state)
        DELAY, SHIFT: begin
          if ((state == SHIFT) && (cnt == CNT_W'(DATA_W))) begin
            state_next = PAD;
          end else begin
            state_next = SHIFT;
            cnt_next   = cnt + CNT_W'(1);
            if (chan) begin
              dac_next  = sh_r[DATA_W-1];
              sh_r_next = {sh_r[DATA_W-2:0], 1'b0};
            end else begin
              dac_next  = sh_l[DATA_W-1];
              sh_l_next = {sh_l[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: ;  // IDLE and PAD drive zero and wait for an edge
      endcase
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      lrck_q       <= 1'b1;   // a low LRCK right after reset is a frame start
      buf_full     <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      sh_l         <= '0;
      sh_r         <= '0;
      chan         <= 1'b0;
      cnt          <= '0;
      o_aud_dacdat <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state        <= state_next;
      lrck_q       <= i_daclrck;
      buf_full     <= buf_full_next;
      sh_l         <= sh_l_next;
      sh_r         <= sh_r_next;
      chan         <= chan_next;
      cnt          <= cnt_next;
      o_aud_dacdat <= dac_next;
      o_underrun   <= und_next;
      if (accept) begin
        buf_l <= i_left_data;
        buf_r <= i_right_data;
      end
    end
  end

endmodule

// File: tb/tb_aud_player_stereo.sv
// Testbench for aud_player_stereo. It runs two instances from one stimulus
// stream: a 16-bit I2S instance and a 24-bit left-justified instance. A
// behavioural model works in terms of the position within the half-frame. At
// every posedge it pushes the expected outputs into a queue, and a monitor on
// the negedge pops that queue and compares.
module tb_aud_player_stereo;

  logic        clk;
  logic        rst_n;
  logic        lrck;
  logic        en;
  logic        valid;
  logic [23:0] l_data;
  logic [23:0] r_data;
  logic        rdy16, dac16, und16;
  logic        rdy24, dac24, und24;

  aud_player_stereo #(.DATA_W(16), .I2S_MODE(1'b1)) dut16 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lrck), .i_en(en),
    .i_left_data(l_data[15:0]), .i_right_data(r_data[15:0]), .i_valid(valid),
    .o_ready(rdy16), .o_aud_dacdat(dac16), .o_underrun(und16)
  );

  aud_player_stereo #(.DATA_W(24), .I2S_MODE(1'b0)) dut24 (
    .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lrck), .i_en(en),
    .i_left_data(l_data), .i_right_data(r_data), .i_valid(valid),
    .o_ready(rdy24), .o_aud_dacdat(dac24), .o_underrun(und24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit d16;
    bit d24;
    bit rdy;
    bit und;
  } exp_t;
  exp_t exp_q[$];

  // model state
  bit        m_full, m_play, m_chan, m_prev, m_acc;
  bit [23:0] m_l, m_r, m_cl, m_cr;
  int        m_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Bit on the wire pos cycles after the edge was seen; I2S adds one cycle.
  function automatic bit exp_bit(input bit [31:0] s, input int w, input bit i2s, input int pos);
    int k;
    k = i2s ? pos - 1 : pos;
    if (k < 0 || k >= w) return 1'b0;
    return s[w-1-k];
  endfunction

  task automatic model_reset();
    m_full = 0; m_play = 0; m_chan = 0; m_prev = 1; m_acc = 0;
    m_l = 0; m_r = 0; m_cl = 0; m_cr = 0; m_pos = 0;
  endtask

  task automatic model_step();
    bit   f, r, und, acc;
    bit [23:0] s;
    exp_t e;
    f = m_prev && !lrck;
    r = !m_prev && lrck;
    m_prev = lrck;
    acc = valid && !m_full;
    und = 0;
    if (!en) begin
      m_play = 0;
    end else if (f) begin
      if (m_full) begin
        m_cl = m_l; m_cr = m_r; m_full = 0;
      end else begin
        m_cl = 0; m_cr = 0; und = 1;
      end
      m_play = 1; m_chan = 0; m_pos = 0;
    end else if (r && m_play) begin
      m_chan = 1; m_pos = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      m_full = 1; m_l = l_data; m_r = r_data;
    end
    m_acc = acc;
    s = m_chan ? m_cr : m_cl;
    e.d16 = m_play ? exp_bit({16'd0, s[15:0]}, 16, 1'b1, m_pos) : 1'b0;
    e.d24 = m_play ? exp_bit({8'd0, s}, 24, 1'b0, m_pos) : 1'b0;
    e.rdy = !m_full;
    e.und = und;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    if (m_acc) begin
      valid = 1'b0;
      m_acc = 0;
    end
  endtask

  task automatic offer(input bit [23:0] l, input bit [23:0] r);
    valid  = 1'b1;
    l_data = l;
    r_data = r;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready16", rdy16, 1'b1);
    chk("rst_dac16",   dac16, 1'b0);
    chk("rst_und16",   und16, 1'b0);
    chk("rst_ready24", rdy24, 1'b1);
    chk("rst_dac24",   dac24, 1'b0);
    chk("rst_und24",   und24, 1'b0);
  endtask

  // One half-frame: drive LRCK to lvl for n cycles, with optional enable
  // changes, a mid-frame reset and random offers.
  task automatic run_half(input bit lvl, input int n, input int off_at, input int on_at,
                          input int rst_at, input bit rnd);
    lrck = lvl;
    for (int c = 0; c < n; c++) begin
      if (c == off_at) en = 1'b0;
      if (c == on_at)  en = 1'b1;
      if (rnd && !valid && $urandom_range(0, 5) == 0)
        offer(24'($urandom), 24'($urandom));
      if (c == rst_at) begin
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
      end else begin
        tick();
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dac16", dac16, e.d16);
      chk("dac24", dac24, e.d24);
      chk("ready16", rdy16, e.rdy);
      chk("ready24", rdy24, e.rdy);
      chk("underrun16", und16, e.und);
      chk("underrun24", und24, e.und);
    end
  end

  initial begin
    rst_n = 1'b0; lrck = 1'b1; en = 1'b1; valid = 1'b0; l_data = '0; r_data = '0;
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // I2S 16-bit pattern / LJ data on the same pair
    offer(24'h12A5F0, 24'h340F0F);
    run_half(1, 4, -1, -1, -1, 0);
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);

    // LJ 24-bit 0x800001
    offer(24'h800001, 24'h7FFFFE);
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);

    // underrun frame, then a pair offered on the frame-start edge
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);
    offer(24'hC3C3C3, 24'h5A5A5A);
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);

    // truncation: 16 BCLK per half-frame
    for (int i = 0; i < 3; i++) begin
      offer(24'($urandom), 24'($urandom));
      run_half(0, 16, -1, -1, -1, 0);
      run_half(1, 16, -1, -1, -1, 0);
    end

    // disable mid-left, re-enable during high LRCK
    offer(24'hF0F0F0, 24'h0F0F0F);
    run_half(1, 8, -1, -1, -1, 0);
    run_half(0, 32, 8, -1, -1, 0);
    offer(24'hABCDEF, 24'h123456);
    run_half(1, 32, -1, 5, -1, 0);
    run_half(0, 32, -1, -1, -1, 0);
    run_half(1, 32, -1, -1, -1, 0);

    // reset mid-frame while LRCK is low
    offer(24'h999999, 24'h666666);
    run_half(0, 32, -1, -1, 10, 0);
    run_half(1, 32, -1, -1, -1, 0);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      int len_l, len_r, off;
      len_l = $urandom_range(14, 40);
      len_r = $urandom_range(14, 40);
      en = ($urandom_range(0, 7) != 0);
      off = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 12) : -1;
      run_half(0, len_l, off, -1, -1, 1);
      run_half(1, len_r, -1, ($urandom_range(0, 3) == 0) ? 3 : -1, -1, 1);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
